// File: rtl/alu_issue_unit.sv
// Issue/response sequencer for the combinational 4-bit ALU: command FIFO in, registered response out.
// Optional operand chaining (previous result as A) is enabled by defining ALU_ISSUE_CHAIN_EN.
module alu_issue_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    input  logic       cmd_chain,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_err,
    output logic [3:0] rsp_tag
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Both ports transfer on a rising edge where valid && ready; a producer holds
    // its payload stable while valid is high and ready is low.

    logic [3:0]    a_mem_q   [DEPTH];
    logic [3:0]    b_mem_q   [DEPTH];
    logic [2:0]    op_mem_q  [DEPTH];
    logic [3:0]    tag_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    tag_q, tag_d;

    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_result_q, rsp_result_d;
    logic          rsp_carry_q, rsp_carry_d;
    logic          rsp_err_q, rsp_err_d;
    logic [3:0]    rsp_tag_q, rsp_tag_d;

    logic          full, empty, push, capture;
    logic [3:0]    head_a, head_b;
    logic [2:0]    head_op;
    logic          div_zero;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = cmd_valid && !full;
    assign capture = !empty && (!rsp_valid_q || rsp_ready);

    assign head_b  = b_mem_q[rd_ptr_q];
    assign head_op = op_mem_q[rd_ptr_q];

`ifdef ALU_ISSUE_CHAIN_EN
    logic          chain_mem_q [DEPTH];
    logic [7:0]    last_q;

    assign head_a = chain_mem_q[rd_ptr_q] ? last_q[3:0] : a_mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (capture) begin
            last_q <= rsp_result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            chain_mem_q[wr_ptr_q] <= cmd_chain;
        end
    end
`else
    logic unused_chain;
    assign unused_chain = cmd_chain;
    assign head_a       = a_mem_q[rd_ptr_q];
`endif

    assign alu_a      = empty ? 4'h0 : head_a;
    assign alu_b      = empty ? 4'h0 : head_b;
    assign alu_opcode = empty ? 3'h0 : head_op;

    assign div_zero   = (head_op == 3'b011) && (head_b == 4'h0);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        tag_d        = tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        rsp_tag_d    = rsp_tag_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            tag_d    = tag_q + 4'd1;
        end

        if (capture) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            rsp_valid_d  = 1'b1;
            rsp_result_d = div_zero ? 8'h00 : alu_result;
            rsp_carry_d  = (head_op == 3'b000) ? alu_carry : 1'b0;
            rsp_err_d    = div_zero;
            rsp_tag_d    = tag_mem_q[rd_ptr_q];
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end

        case ({push, capture})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    // Entry storage is only ever read behind the count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem_q[wr_ptr_q]   <= cmd_a;
            b_mem_q[wr_ptr_q]   <= cmd_b;
            op_mem_q[wr_ptr_q]  <= cmd_op;
            tag_mem_q[wr_ptr_q] <= tag_q;
        end
    end

    assign cmd_ready  = !full;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = (rsp_result_q == 8'h00);
    assign rsp_err    = rsp_err_q;
    assign rsp_tag    = rsp_tag_q;

endmodule
